// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver.
// The rx line is resynchronised, a falling edge starts a frame, and the start
// bit is confirmed half a bit period later. Every later sample then lands one
// full bit period after the previous one, which puts it in the middle of each
// data bit and of the stop bit. The bit period is captured at the start of a
// frame, so changes to clk_div while a frame is in progress have no effect on it.
module uart_rx #(
  parameter int SYNC_STAGES = 2  // metastability flops on rx, at least 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic [15:0] clk_div,
  output logic [7:0]  dout,
  output logic        valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;
  logic                   fall;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] half;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  dout_q, dout_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  // Synchroniser chain; the line idles high, so every flop resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '1;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_prev_q <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_prev_q & ~rx_s;
  assign half = {1'b0, div_q[15:1]};

  // State and datapath registers of the frame sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic: bit timing, sampling, shifting and strobe generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          div_d   = clk_div;
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == half) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          // A line that is already high again was only a glitch.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DATA: begin
        if (cnt_q == div_q) begin
          cnt_d     = '0;
          sh_d      = {rx_s, sh_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      STOP: begin
        if (cnt_q == div_q) begin
          cnt_d = '0;
          if (rx_s) begin
            dout_d  = sh_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      BRK: begin
        // Hold here while the line stays low so a break cannot start a frame.
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

  // Structural invariants of the sequencer.
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(valid_q && ferr_q));
  a_valid_idle: assert property (@(posedge clk) disable iff (!rst_n)
    valid_q |-> (state_q == IDLE));
  a_ferr_brk: assert property (@(posedge clk) disable iff (!rst_n)
    ferr_q |-> (state_q == BRK));
  a_idle_cnt: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) |-> (cnt_q == 16'd0));

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Stimulus pushes the expected
// strobe (good byte or framing error with the byte dout must keep) before
// driving the line; a monitor pops and compares on every valid/frame_err.
module tb_uart_rx;

  localparam int SYNC = 2;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [15:0] clk_div;
  logic [7:0]  dout;
  logic        valid;
  logic        frame_err;
  logic        busy;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       expq[$];
  exp_t       e;
  int         vtimes[$];
  int         cyc;
  int         n_chk;
  int         n_fail;
  logic [7:0] last_good;

  uart_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .clk_div   (clk_div),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      chk("strobe_exclusive", {31'd0, valid && frame_err}, 32'd0);
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b dout=%0h", valid, frame_err, dout);
      end else begin
        e = expq.pop_front();
        chk("strobe_kind_ferr", {31'd0, frame_err}, {31'd0, e.err});
        chk("strobe_dout", {24'd0, dout}, {24'd0, e.data});
        if (valid) vtimes.push_back(cyc);
      end
    end
  end

  task automatic expect_good(input logic [7:0] d);
    expq.push_back('{err: 1'b0, data: d});
    last_good = d;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame starting at a falling clock edge; optionally switch
  // clk_div to new_div halfway through data bit sw_bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int p,
                            input int sw_bit, input logic [15:0] new_div);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == sw_bit) begin
        repeat (p / 2) @(negedge clk);
        clk_div = new_div;
        repeat (p - p / 2) @(negedge clk);
      end else begin
        repeat (p) @(negedge clk);
      end
    end
    rx = stop;
    repeat (p) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    cyc       = 0;
    n_chk     = 0;
    n_fail    = 0;
    last_good = 8'h00;
    rx        = 1'b1;
    clk_div   = 16'd15;
    rst_n     = 1'b0;

    // Reset state.
    repeat (4) @(negedge clk);
    chk("reset_dout", {24'd0, dout}, 32'h00);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single frame 8'hA5 at P=16.
    expect_good(8'hA5);
    send_frame(8'hA5, 1'b1, 16, -1, 16'd0);
    idle(32);
    chk("a5_busy_after", {31'd0, busy}, 32'd0);
    chk("a5_dout_held", {24'd0, dout}, 32'hA5);

    // Back-to-back frames with no idle gap.
    vtimes.delete();
    expect_good(8'h00);
    expect_good(8'hFF);
    expect_good(8'h81);
    send_frame(8'h00, 1'b1, 16, -1, 16'd0);
    send_frame(8'hFF, 1'b1, 16, -1, 16'd0);
    send_frame(8'h81, 1'b1, 16, -1, 16'd0);
    idle(40);
    chk("b2b_valid_count", vtimes.size(), 32'd3);
    if (vtimes.size() == 3) begin
      chk("b2b_spacing_1", vtimes[1] - vtimes[0], 32'd160);
      chk("b2b_spacing_2", vtimes[2] - vtimes[1], 32'd160);
    end

    // Glitch: 4 low cycles must be rejected; busy clears within H+SYNC+2.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_rises", {31'd0, busy}, 32'd1);
    repeat (7 + SYNC + 2 - 5) @(negedge clk);
    chk("glitch_busy_drops", {31'd0, busy}, 32'd0);
    idle(30);

    // Bad stop bit followed by a 40-cycle break.
    expq.push_back('{err: 1'b1, data: last_good});
    send_frame(8'h3C, 1'b0, 16, -1, 16'd0);
    repeat (40) @(negedge clk);
    chk("break_busy_held", {31'd0, busy}, 32'd1);
    chk("break_dout_kept", {24'd0, dout}, 32'h81);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_released", {31'd0, busy}, 32'd0);
    idle(16);
    expect_good(8'hC3);
    send_frame(8'hC3, 1'b1, 16, -1, 16'd0);
    idle(32);
    chk("after_break_dout", {24'd0, dout}, 32'hC3);

    // Reset during data bit 4 of 8'h77 abandons the frame.
    rb = 8'h77;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      repeat (16) @(negedge clk);
    end
    rx = rb[4];
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_dout", {24'd0, dout}, 32'h00);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    rst_n     = 1'b1;
    last_good = 8'h00;
    idle(40);
    chk("midrst_idle_after", {31'd0, busy}, 32'd0);
    expect_good(8'h5A);
    send_frame(8'h5A, 1'b1, 16, -1, 16'd0);
    idle(32);

    // clk_div changes 15 -> 7 during data bit 2; next frame at P=8.
    expect_good(8'h96);
    send_frame(8'h96, 1'b1, 16, 2, 16'd7);
    idle(32);
    expect_good(8'h2B);
    send_frame(8'h2B, 1'b1, 8, -1, 16'd0);
    idle(32);
    chk("final_dout", {24'd0, dout}, 32'h2B);

    // Drain: every expected strobe must have arrived.
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
